// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/acknowledge bus between the LSU memory stage (master) and data memory (slave).
// Request fields are held stable from the first request cycle until the ack cycle.
interface lsu_mem_stage_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I memory stage: one request/ack memory transaction per load/store, aligned/extended load data.
// Result 1 cycle after ack (or after acceptance for ALU/fault ops); stalls upstream while a transaction is open.
module lsu_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  wb_sel_i,
  output logic        stall_o,
  lsu_mem_stage_if.master mem,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [2:0]  wb_sel_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] load_data_o,
  output logic        fault_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic        mem_op, misaligned, illegal, bad_access;
  logic        accept_mem, retire;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode of the incoming access; only meaningful when mem_op is set.
  always_comb begin
    mem_op     = load_i | store_i;
    misaligned = ((funct3_i[1:0] == 2'd1) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'd2) && (addr_i[1:0] != 2'b00));
    illegal    = load_i ? ((funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7))
                        : (funct3_i > 3'd2);
    bad_access = misaligned | illegal;
    case (funct3_i[1:0])
      2'd0:    be_calc = 4'b0001 << addr_i[1:0];
      2'd1:    be_calc = addr_i[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase
    case (funct3_i[1:0])
      2'd0:    wdata_calc = {4{wdata_i[7:0]}};
      2'd1:    wdata_calc = {2{wdata_i[15:0]}};
      default: wdata_calc = wdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stall_o    = 1'b0;
    accept_mem = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i && mem_op && !bad_access) begin
          accept_mem = 1'b1;
          stall_o    = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        stall_o = ~mem.mem_ack_i;
        if (mem.mem_ack_i) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (req_q.addr[1:0])
      2'd0:    ld_byte = mem.mem_rdata_i[7:0];
      2'd1:    ld_byte = mem.mem_rdata_i[15:8];
      2'd2:    ld_byte = mem.mem_rdata_i[23:16];
      default: ld_byte = mem.mem_rdata_i[31:24];
    endcase
    ld_half = req_q.addr[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    case (req_q.funct3)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = mem.mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      wb_valid_o   <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_rd_o      <= 5'd0;
      wb_sel_o     <= 3'd0;
      alu_result_o <= 32'd0;
      load_data_o  <= 32'd0;
      fault_o      <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      fault_o    <= 1'b0;
      if (state == IDLE && valid_i) begin
        if (!mem_op) begin
          wb_valid_o   <= 1'b1;
          wb_we_o      <= (rd_i != 5'd0);
          wb_rd_o      <= rd_i;
          wb_sel_o     <= wb_sel_i;
          alu_result_o <= addr_i;
        end else if (bad_access) begin
          fault_o <= 1'b1;
          wb_we_o <= 1'b0;
        end
      end
      if (accept_mem) begin
        req_q <= '{we: store_i, funct3: funct3_i, rd: rd_i, sel: wb_sel_i,
                   addr: addr_i, be: be_calc, wdata: wdata_calc};
      end
      if (retire) begin
        wb_valid_o   <= 1'b1;
        wb_we_o      <= !req_q.we && (req_q.rd != 5'd0);
        wb_rd_o      <= req_q.rd;
        wb_sel_o     <= req_q.sel;
        alu_result_o <= req_q.addr;
        if (!req_q.we) load_data_o <= ld_ext;
      end
    end
  end

  assign mem.mem_req_o   = (state == BUSY);
  assign mem.mem_we_o    = req_q.we;
  assign mem.mem_addr_o  = {req_q.addr[31:2], 2'b00};
  assign mem.mem_be_o    = req_q.be;
  assign mem.mem_wdata_o = req_q.wdata;

endmodule
